// File: rtl/decoder_port_arbiter_pkg.sv
// Shared definitions for the decoded write-port arbiter: FSM state
// encoding and a reference round-robin pick function.
package arb_pkg;

    // Widest requester vector the helper function accepts
    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Result of a round-robin pick: winning index plus "anyone requesting"
    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // Behavioural round-robin pick: the first set bit of req searching
    // ptr, ptr+1, ... modulo nreq. Scanning offsets from high to low
    // lets the smallest offset overwrite the result last and win.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input logic [2:0]          ptr,
        input int                  nreq
    );
        rr_pick_t r;
        int       j;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int k = nreq - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % nreq;
            if (req[j]) begin
                r.valid = 1'b1;
                r.idx   = 3'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_port_arbiter_picker.sv
// Combinational round-robin priority picker: rotates the request vector
// so the priority pointer sits at bit 0, finds the first set bit, then
// rotates the winning offset back into an absolute requester index.
module rr_priority_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]  w_rot;
    logic             w_found;
    logic [IDX_W-1:0] w_off;

    // Rotate requests right by ptr; NREQ is a power of two, so the
    // IDX_W-bit sum wraps modulo NREQ on its own
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = req[IDX_W'(i) + ptr];
        end
    end

    // Find the lowest set bit of the rotated vector; scanning downwards
    // leaves the lowest index as the final assignment
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = IDX_W'(i);
            end
        end
    end

    assign valid = w_found;
    assign idx   = w_off + ptr;

endmodule

// File: rtl/decoder_port_arbiter.sv
// Round-robin arbiter and sequencer for one shared, gate-level decoded
// write port. A winning requester's address and data are latched and
// held with port_en high for SETTLE cycles so the decoder tree settles,
// then the requester gets a one-cycle ack and priority rotates past it.
module decoder_port_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   addr_in,
    input  logic [NREQ*DATA_W-1:0]   data_in,
    output logic [NREQ-1:0]          ack,
    output logic                     port_en,
    output logic [ADDR_W-1:0]        port_addr,
    output logic [DATA_W-1:0]        port_data,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NREQ);
    // Counter holds SETTLE-1 down to 0; keep at least one bit for SETTLE=1
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    arb_state_t        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_portEn;
    logic [ADDR_W-1:0] r_portAddr;
    logic [DATA_W-1:0] r_portData;
    logic [NREQ-1:0]   r_ack;
    logic [IDX_W-1:0]  r_grant;
    logic              r_busy;

    logic              w_pickValid;
    logic [IDX_W-1:0]  w_pickIdx;

    rr_priority_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pickValid),
        .idx   (w_pickIdx)
    );

    // Sequencer FSM: grant and latch in IDLE, hold the port in HOLD,
    // pulse ack and rotate the pointer in DONE; every output is registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_portEn   <= 1'b0;
            r_portAddr <= '0;
            r_portData <= '0;
            r_ack      <= '0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= '0;
                    if (w_pickValid) begin
                        r_portAddr <= addr_in[int'(w_pickIdx)*ADDR_W +: ADDR_W];
                        r_portData <= data_in[int'(w_pickIdx)*DATA_W +: DATA_W];
                        r_grant    <= w_pickIdx;
                        r_cnt      <= CNT_W'(SETTLE - 1);
                        r_portEn   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_portEn <= 1'b0;
                        r_ack    <= NREQ'(1) << r_grant;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= r_grant + 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_portEn <= 1'b0;
                    r_ack    <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign port_en   = r_portEn;
    assign port_addr = r_portAddr;
    assign port_data = r_portData;
    assign grant_id  = r_grant;
    assign busy      = r_busy;

endmodule

// File: tb/tb_decoder_port_arbiter.sv
// Directed bench for decoder_port_arbiter: a SETTLE=2 instance driven by
// hand-computed vectors and sequences, plus a SETTLE=1 instance.
module tb_decoder_port_arbiter;

    logic         clk = 1'b0;
    logic         reset;

    logic [3:0]   req0, req1;
    logic [19:0]  addrIn0, addrIn1;
    logic [255:0] dataIn0, dataIn1;

    logic [3:0]   ack0, ack1;
    logic         portEn0, portEn1;
    logic [4:0]   portAddr0, portAddr1;
    logic [63:0]  portData0, portData1;
    logic [1:0]   grantId0, grantId1;
    logic         busy0, busy1;

    logic [3:0]   sAck;
    logic         sPe;
    logic [4:0]   sAddr;
    logic [63:0]  sData;
    logic [1:0]   sGrant;
    logic         sBusy;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    typedef struct {
        logic [3:0]  req;
        int          expGrant;
        logic [4:0]  expAddr;
        logic [63:0] expData;
    } vec_t;

    vec_t vecs [8];

    decoder_port_arbiter #(.NREQ(4), .ADDR_W(5), .DATA_W(64), .SETTLE(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req0),
        .addr_in   (addrIn0),
        .data_in   (dataIn0),
        .ack       (ack0),
        .port_en   (portEn0),
        .port_addr (portAddr0),
        .port_data (portData0),
        .grant_id  (grantId0),
        .busy      (busy0)
    );

    decoder_port_arbiter #(.NREQ(4), .ADDR_W(5), .DATA_W(64), .SETTLE(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .req       (req1),
        .addr_in   (addrIn1),
        .data_in   (dataIn1),
        .ack       (ack1),
        .port_en   (portEn1),
        .port_addr (portAddr1),
        .port_data (portData1),
        .grant_id  (grantId1),
        .busy      (busy1)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to measure ack spacing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [3:0] r);
        if (sel == 0) req0 = r;
        else          req1 = r;
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic setDefaults();
        for (int i = 0; i < 4; i++) begin
            addrIn0[i*5 +: 5]   = 5'(3*i + 1);
            addrIn1[i*5 +: 5]   = 5'(3*i + 1);
            dataIn0[i*64 +: 64] = 64'hA5A5_A5A5_0000_0000 + 64'(i);
            dataIn1[i*64 +: 64] = 64'hA5A5_A5A5_0000_0000 + 64'(i);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            sAck = ack0; sPe = portEn0; sAddr = portAddr0;
            sData = portData0; sGrant = grantId0; sBusy = busy0;
        end else begin
            sAck = ack1; sPe = portEn1; sAddr = portAddr1;
            sData = portData1; sGrant = grantId1; sBusy = busy1;
        end
    endtask

    task automatic checkIdleZero(input int sel, input string tag);
        sample(sel);
        checkOutput({tag, " port_en"},   64'(sPe),    64'd0);
        checkOutput({tag, " ack"},       64'(sAck),   64'd0);
        checkOutput({tag, " busy"},      64'(sBusy),  64'd0);
        checkOutput({tag, " grant_id"},  64'(sGrant), 64'd0);
        checkOutput({tag, " port_addr"}, 64'(sAddr),  64'd0);
        checkOutput({tag, " port_data"}, sData,       64'd0);
    endtask

    // Follow one transaction from the grant through the ack cycle and the
    // following IDLE cycle; drops the winner's req when ack is seen
    task automatic runTxn(input int sel, input int expG, input logic [4:0] expAddr,
                          input logic [63:0] expData, input bit disturb,
                          input string tag, output int ackAt);
        int settle;
        int w;
        settle = (sel == 0) ? 2 : 1;
        w = 0;
        sample(sel);
        while (sPe !== 1'b1 && w < 20) begin
            @(negedge clk);
            sample(sel);
            w++;
        end
        checkOutput({tag, " grant seen"}, 64'(sPe), 64'd1);
        for (int h = 0; h < settle; h++) begin
            sample(sel);
            checkOutput({tag, " hold port_en"},   64'(sPe),    64'd1);
            checkOutput({tag, " hold port_addr"}, 64'(sAddr),  64'(expAddr));
            checkOutput({tag, " hold port_data"}, sData,       expData);
            checkOutput({tag, " hold busy"},      64'(sBusy),  64'd1);
            checkOutput({tag, " hold ack"},       64'(sAck),   64'd0);
            checkOutput({tag, " hold grant_id"},  64'(sGrant), 64'(expG));
            if (disturb && h == 0) begin
                req0[expG]            = 1'b0;
                addrIn0[expG*5 +: 5]  = ~expAddr;
                dataIn0[expG*64 +: 64] = ~expData;
            end
            @(negedge clk);
        end
        sample(sel);
        ackAt = cyc;
        checkOutput({tag, " done port_en"},  64'(sPe),    64'd0);
        checkOutput({tag, " done ack"},      64'(sAck),   64'(4'b0001 << expG));
        checkOutput({tag, " done busy"},     64'(sBusy),  64'd1);
        checkOutput({tag, " done grant_id"}, 64'(sGrant), 64'(expG));
        if (sel == 0) req0[expG] = 1'b0;
        else          req1[expG] = 1'b0;
        @(negedge clk);
        sample(sel);
        checkOutput({tag, " idle ack"},       64'(sAck),   64'd0);
        checkOutput({tag, " idle busy"},      64'(sBusy),  64'd0);
        checkOutput({tag, " idle port_en"},   64'(sPe),    64'd0);
        checkOutput({tag, " idle grant_id"},  64'(sGrant), 64'(expG));
        checkOutput({tag, " idle port_addr"}, 64'(sAddr),  64'(expAddr));
    endtask

    initial begin
        int a0, a1, a2, a3;
        int w;

        // Expected picks starting with the pointer at 1 after the wrap test
        vecs[0] = '{4'b0001, 0, 5'd1,  64'hA5A5_A5A5_0000_0000};
        vecs[1] = '{4'b0101, 2, 5'd7,  64'hA5A5_A5A5_0000_0002};
        vecs[2] = '{4'b0111, 0, 5'd1,  64'hA5A5_A5A5_0000_0000};
        vecs[3] = '{4'b1010, 1, 5'd4,  64'hA5A5_A5A5_0000_0001};
        vecs[4] = '{4'b0011, 0, 5'd1,  64'hA5A5_A5A5_0000_0000};
        vecs[5] = '{4'b1100, 2, 5'd7,  64'hA5A5_A5A5_0000_0002};
        vecs[6] = '{4'b1110, 3, 5'd10, 64'hA5A5_A5A5_0000_0003};
        vecs[7] = '{4'b0110, 1, 5'd4,  64'hA5A5_A5A5_0000_0001};

        reset = 1'b1;
        req0  = '0;
        req1  = '0;
        setDefaults();

        applyReset(2);
        checkIdleZero(0, "reset dut");
        checkIdleZero(1, "reset dut1");

        $display("[TB] single request after reset");
        addrIn0[2*5 +: 5]   = 5'd17;
        dataIn0[2*64 +: 64] = 64'h0000_0000_DEAD_BEEF;
        applyStimulus(0, 4'b0100);
        runTxn(0, 2, 5'd17, 64'h0000_0000_DEAD_BEEF, 1'b0, "single", a0);
        setDefaults();

        $display("[TB] wrap-around from pointer 3");
        applyStimulus(0, 4'b1001);
        runTxn(0, 3, 5'd10, 64'hA5A5_A5A5_0000_0003, 1'b0, "wrap first", a0);
        runTxn(0, 0, 5'd1,  64'hA5A5_A5A5_0000_0000, 1'b0, "wrap second", a1);
        applyStimulus(0, 4'b0000);

        $display("[TB] table vectors");
        for (int v = 0; v < 8; v++) begin
            applyStimulus(0, vecs[v].req);
            runTxn(0, vecs[v].expGrant, vecs[v].expAddr, vecs[v].expData, 1'b0,
                   $sformatf("vec%0d", v), a0);
            applyStimulus(0, 4'b0000);
        end

        $display("[TB] all four requesting from pointer 0");
        applyReset(2);
        applyStimulus(0, 4'b1111);
        runTxn(0, 0, 5'd1,  64'hA5A5_A5A5_0000_0000, 1'b0, "all r0", a0);
        runTxn(0, 1, 5'd4,  64'hA5A5_A5A5_0000_0001, 1'b0, "all r1", a1);
        runTxn(0, 2, 5'd7,  64'hA5A5_A5A5_0000_0002, 1'b0, "all r2", a2);
        runTxn(0, 3, 5'd10, 64'hA5A5_A5A5_0000_0003, 1'b0, "all r3", a3);
        checkOutput("all spacing 0-1", 64'(a1 - a0), 64'd4);
        checkOutput("all spacing 1-2", 64'(a2 - a1), 64'd4);
        checkOutput("all spacing 2-3", 64'(a3 - a2), 64'd4);
        applyStimulus(0, 4'b0000);

        $display("[TB] req drop and address change during hold");
        addrIn0[4:0]  = 5'd3;
        dataIn0[63:0] = 64'h0000_0000_0000_0444;
        applyStimulus(0, 4'b0001);
        runTxn(0, 0, 5'd3, 64'h0000_0000_0000_0444, 1'b1, "disturb", a0);
        applyStimulus(0, 4'b0000);
        setDefaults();

        $display("[TB] reset during second hold cycle");
        applyStimulus(0, 4'b0010);
        w = 0;
        while (portEn0 !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("abort grant seen", 64'(portEn0), 64'd1);
        @(negedge clk);
        checkOutput("abort second hold", 64'(portEn0), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        checkIdleZero(0, "abort");
        reset = 1'b0;
        applyStimulus(0, 4'b1010);
        runTxn(0, 1, 5'd4,  64'hA5A5_A5A5_0000_0001, 1'b0, "post reset r1", a0);
        runTxn(0, 3, 5'd10, 64'hA5A5_A5A5_0000_0003, 1'b0, "post reset r3", a1);
        applyStimulus(0, 4'b0000);

        $display("[TB] SETTLE=1 back-to-back");
        applyStimulus(1, 4'b0110);
        runTxn(1, 1, 5'd4, 64'hA5A5_A5A5_0000_0001, 1'b0, "s1 r1", a0);
        runTxn(1, 2, 5'd7, 64'hA5A5_A5A5_0000_0002, 1'b0, "s1 r2", a1);
        checkOutput("s1 spacing", 64'(a1 - a0), 64'd3);
        applyStimulus(1, 4'b0000);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
